// File: rtl/pipe_mux_reg.sv
// N-way channel select feeding a 2-entry skid buffer.
// Registered in_ready; flush squashes all buffered beats.
module pipe_mux_reg #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*NUM_IN-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main_data;
  logic [SEL_W-1:0] r_main_sel;
  logic [WIDTH-1:0] r_skid_data;
  logic [SEL_W-1:0] r_skid_sel;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_sel_err;

  logic             w_acc;
  logic             w_emit;
  logic             w_sel_ok;
  logic [WIDTH-1:0] w_mux_data;
  logic [SEL_W-1:0] w_mux_sel;

  assign w_acc    = in_valid & r_in_ready;
  assign w_emit   = r_out_valid & out_ready;
  assign w_sel_ok = 32'(sel) < NUM_IN;

  // Illegal selects match no channel and fall back to channel 0.
  always_comb begin
    w_mux_data = in_data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_mux_data = in_data[k*WIDTH +: WIDTH];
      end
    end
    w_mux_sel = w_sel_ok ? sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_sel  <= '0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_sel_err   <= 1'b0;
    end else begin
      // The error pulse fires even when flush discards the beat.
      r_sel_err <= w_acc & ~w_sel_ok;
      if (flush) begin
        r_state     <= S_EMPTY;
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_acc) begin
              r_main_data <= w_mux_data;
              r_main_sel  <= w_mux_sel;
              r_out_valid <= 1'b1;
              r_state     <= S_ONE;
            end
          end
          S_ONE: begin
            unique case (1'b1)
              w_acc & ~w_emit: begin
                r_skid_data <= w_mux_data;
                r_skid_sel  <= w_mux_sel;
                r_in_ready  <= 1'b0;
                r_state     <= S_FULL;
              end
              w_acc & w_emit: begin
                r_main_data <= w_mux_data;
                r_main_sel  <= w_mux_sel;
              end
              ~w_acc & w_emit: begin
                r_out_valid <= 1'b0;
                r_state     <= S_EMPTY;
              end
              default: begin
              end
            endcase
          end
          S_FULL: begin
            if (w_emit) begin
              r_main_data <= r_skid_data;
              r_main_sel  <= r_skid_sel;
              r_in_ready  <= 1'b1;
              r_state     <= S_ONE;
            end
          end
          default: begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_EMPTY;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_main_data;
  assign out_sel   = r_main_sel;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Scoreboard bench for pipe_mux_reg (4-way main
// instance, 3-way instance for illegal selects).
module tb_pipe_mux_reg;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W*N-1:0] in_data;
  logic [SW-1:0]  sel;
  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;
  logic           sel_err;

  logic           r3;
  logic [W*3-1:0] d3_in_data;
  logic [1:0]     d3_sel;
  logic           d3_in_valid;
  logic           d3_in_ready;
  logic           d3_flush;
  logic [W-1:0]   d3_out_data;
  logic [1:0]     d3_out_sel;
  logic           d3_out_valid;
  logic           d3_out_ready;
  logic           d3_sel_err;

  always #5 clk = ~clk;

  pipe_mux_reg #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  pipe_mux_reg #(.WIDTH(W), .NUM_IN(3)) dut3 (
    .clk(clk), .rst(r3), .in_data(d3_in_data),
    .sel(d3_sel), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .flush(d3_flush),
    .out_data(d3_out_data), .out_sel(d3_out_sel),
    .out_valid(d3_out_valid),
    .out_ready(d3_out_ready),
    .sel_err(d3_sel_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_emit = 0;
  bit mon_en = 1'b0;
  logic [SW+W-1:0] q[$];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Reference model: queue of {sel, data} in accept order.
  always @(negedge clk) begin
    if (mon_en) begin
      logic acc;
      logic emt;
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("sel_err", sel_err, 0);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0][W-1:0]);
        chk("out_sel", out_sel, q[0][SW+W-1:W]);
      end
      acc = in_valid && (q.size() < 2);
      emt = (q.size() != 0) && out_ready;
      if (rst || flush) begin
        q.delete();
      end else begin
        if (emt) begin
          void'(q.pop_front());
          n_emit++;
        end
        if (acc)
          q.push_back({sel, in_data[sel*W +: W]});
      end
    end
  end

  task automatic rnd_data();
    for (int k = 0; k < N * 2; k++)
      in_data[k*32 +: 32] = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted.
  task automatic beat(input logic [SW-1:0] s);
    bit done = 1'b0;
    in_valid = 1'b1;
    sel = s;
    rnd_data();
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      step();
    end
    if (!done) chk("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    time t0;
    int e0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sel = '0;
    in_data = '0;
    r3 = 1'b1;
    d3_in_data = '0;
    d3_sel = '0;
    d3_in_valid = 1'b0;
    d3_flush = 1'b0;
    d3_out_ready = 1'b1;
    step();
    mon_en = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_err", sel_err, 0);
    step();
    rst = 1'b0;

    // Single beat, empty buffer: one-cycle latency.
    rnd_data();
    in_data[2*W +: W] = 64'hA5A5_0000_0000_0002;
    sel = 2'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 64'hA5A5_0000_0000_0002);
    chk("lat_sel", out_sel, 2);
    step();

    // Fill to FULL, then drain in order.
    out_ready = 1'b0;
    beat(2'd0);
    beat(2'd1);
    chk("full_rdy", in_ready, 0);
    out_ready = 1'b1;
    beat(2'd3);
    repeat (4) step();
    chk("drain_rdy", in_ready, 1);

    // Streaming: one beat per cycle, never FULL.
    e0 = n_emit;
    t0 = $time;
    for (int k = 0; k < 8; k++) beat(2'(k));
    chk("stream_cyc", ($time - t0) / 10, 8);
    repeat (2) step();
    chk("stream_emit", n_emit - e0, 8);

    // Flush from FULL squashes buffer and new beat.
    out_ready = 1'b0;
    beat(2'd1);
    beat(2'd2);
    e0 = n_emit;
    rnd_data();
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_emit", n_emit - e0, 0);

    // Reset together with flush while holding one beat.
    out_ready = 1'b0;
    beat(2'd3);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    chk("rf_valid", out_valid, 0);
    chk("rf_ready", in_ready, 1);
    chk("rf_data", out_data, 0);
    chk("rf_sel", out_sel, 0);
    chk("rf_err", sel_err, 0);
    t0 = $time;
    beat(2'd1);
    chk("rf_acc_cyc", ($time - t0) / 10, 1);
    out_ready = 1'b1;
    repeat (2) step();

    // Random traffic with occasional flush.
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'($urandom);
      sel = 2'($urandom);
      rnd_data();
      out_ready = 1'($urandom);
      flush = ($urandom_range(15) == 0);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rnd_empty", out_valid, 0);

    // Three-way instance: illegal select falls to ch0.
    r3 = 1'b0;
    d3_in_data[0 +: W] = 64'h0123_4567_89AB_CDEF;
    d3_in_data[W +: W] = 64'h1111_2222_3333_4444;
    d3_in_data[2*W +: W] = 64'hDEAD_BEEF_0000_0002;
    d3_sel = 2'd3;
    d3_in_valid = 1'b1;
    step();
    d3_in_valid = 1'b0;
    chk("ill_valid", d3_out_valid, 1);
    chk("ill_sel", d3_out_sel, 0);
    chk("ill_data", d3_out_data, 64'h0123_4567_89AB_CDEF);
    chk("ill_err", d3_sel_err, 1);
    step();
    chk("ill_err_off", d3_sel_err, 0);
    chk("ill_drained", d3_out_valid, 0);
    d3_sel = 2'd2;
    d3_in_valid = 1'b1;
    step();
    d3_in_valid = 1'b0;
    chk("leg_sel", d3_out_sel, 2);
    chk("leg_data", d3_out_data, 64'hDEAD_BEEF_0000_0002);
    chk("leg_err", d3_sel_err, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
